// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and width helpers for the reset sequencer
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } rst_seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Counters and indices need at least one bit even when the range collapses to 1.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - multi-flop synchronizer for a single asynchronous status bit
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged per-domain reset release gated on stable MMCM lock
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_DELAY        = 16,
    parameter int N_STAGES           = 3,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_locked,
    input  logic                 i_force_reset,
    input  logic                 i_clear_lost,
    output logic [N_STAGES-1:0]  o_reset,
    output logic                 o_ready,
    output logic                 o_lock_lost,
    output logic [CNT_WIDTH-1:0] o_loss_count
);

    localparam int CW = clog2_min1(max_int(LOCK_STABLE_CYCLES, STAGE_DELAY));
    localparam int IW = clog2_min1(N_STAGES);
    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_STAGES - 1);

    rst_seq_state_e        state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [N_STAGES-1:0]   rst_q, rst_d;
    logic                  ready_q, ready_d;
    logic                  lk, lk_q;
    logic                  lost_q, lost_d;
    logic [CNT_WIDTH-1:0]  loss_cnt_q, loss_cnt_d;
    logic                  lock_fall;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (i_clock),
        .rst_i (i_reset),
        .d_i   (i_locked),
        .q_o   (lk)
    );

    assign lock_fall = lk_q & ~lk;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;

        case (state_q)
            WAIT_LOCK: begin
                rst_d   = '1;
                ready_d = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
                if (lk) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == STAGE_LAST) begin
                    cnt_d = '0;
                    for (int k = 0; k < N_STAGES; k++) begin
                        if (idx_q == IW'(k)) begin
                            rst_d[k] = 1'b0;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                rst_d   = '0;
                ready_d = 1'b1;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        // Lock loss and forced restart both abort any sequence in progress.
        if ((state_q != WAIT_LOCK) && (!lk || i_force_reset)) begin
            state_d = WAIT_LOCK;
            rst_d   = '1;
            ready_d = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // A loss on the same edge as a clear must survive, so it is applied last.
    always_comb begin
        lost_d     = lost_q;
        loss_cnt_d = loss_cnt_q;
        if (i_clear_lost) begin
            lost_d     = 1'b0;
            loss_cnt_d = '0;
        end
        if (lock_fall) begin
            lost_d = 1'b1;
            if (i_clear_lost) begin
                loss_cnt_d = CNT_WIDTH'(1);
            end else if (loss_cnt_q != '1) begin
                loss_cnt_d = loss_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= WAIT_LOCK;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_q      <= '1;
            ready_q    <= 1'b0;
            lk_q       <= 1'b0;
            lost_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_q      <= rst_d;
            ready_q    <= ready_d;
            lk_q       <= lk;
            lost_q     <= lost_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign o_reset      = rst_q;
    assign o_ready      = ready_q;
    assign o_lock_lost  = lost_q;
    assign o_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed and randomized checks of reset_sequencer against a timing model
module tb_reset_sequencer;

    localparam int SYNC = 2;
    localparam int L    = 8;
    localparam int D    = 4;
    localparam int N    = 3;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_in, locked_in, force_in, clear_in;
    logic [N-1:0]  o_reset;
    logic          o_ready, o_lost;
    logic [CW-1:0] o_cnt;

    reset_sequencer #(
        .SYNC_STAGES        (SYNC),
        .LOCK_STABLE_CYCLES (L),
        .STAGE_DELAY        (D),
        .N_STAGES           (N),
        .CNT_WIDTH          (CW)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_in),
        .i_locked      (locked_in),
        .i_force_reset (force_in),
        .i_clear_lost  (clear_in),
        .o_reset       (o_reset),
        .o_ready       (o_ready),
        .o_lock_lost   (o_lost),
        .o_loss_count  (o_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: lock delay line, plus the edge at which a stable-lock sequence began.
    logic pipe [0:SYNC];
    bit   m_active = 1'b0;
    int   m_start  = 0;
    int   edge_n   = 0;
    bit   m_lost   = 1'b0;
    int   m_cnt    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        logic lk_b, lkq_b;
        edge_n++;
        lk_b  = pipe[SYNC-1];
        lkq_b = pipe[SYNC];
        if (rst_in) begin
            for (int i = 0; i <= SYNC; i++) pipe[i] = 1'b0;
            m_active = 1'b0;
            m_lost   = 1'b0;
            m_cnt    = 0;
        end else begin
            if (clear_in) begin
                m_lost = 1'b0;
                m_cnt  = 0;
            end
            if (lkq_b && !lk_b) begin
                m_lost = 1'b1;
                m_cnt  = clear_in ? 1 : ((m_cnt == CMAX) ? CMAX : m_cnt + 1);
            end
            if (!m_active) begin
                if (lk_b) begin
                    m_active = 1'b1;
                    m_start  = edge_n;
                end
            end else if (!lk_b || force_in) begin
                m_active = 1'b0;
            end
            for (int i = SYNC; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = locked_in;
        end
    endtask

    task automatic check_model();
        logic [N-1:0] er;
        logic         ery;
        int           e;
        er  = '1;
        ery = 1'b0;
        if (m_active) begin
            e = edge_n - m_start;
            for (int k = 0; k < N; k++) begin
                if (e >= L + (k + 1) * D) er[k] = 1'b0;
            end
            ery = (e >= L + N * D);
        end
        chk("m_reset", 32'(o_reset), 32'(er));
        chk("m_ready", 32'(o_ready), 32'(ery));
        chk("m_lost",  32'(o_lost),  32'(m_lost));
        chk("m_count", 32'(o_cnt),   32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        for (int i = 0; i <= SYNC; i++) pipe[i] = 1'b0;
        rst_in = 1'b1; locked_in = 1'b0; force_in = 1'b0; clear_in = 1'b0;
        repeat (3) tick();
        chk("rst_reset", 32'(o_reset), 32'h7);
        chk("rst_ready", 32'(o_ready), 32'h0);
        chk("rst_lost",  32'(o_lost),  32'h0);
        chk("rst_count", 32'(o_cnt),   32'h0);

        // Clean start
        rst_in = 1'b0; locked_in = 1'b1;
        for (int r = 0; r <= 22; r++) begin
            tick();
            if (r == 13) chk("t1_e13", 32'(o_reset), 32'h7);
            if (r == 14) chk("t1_e14", 32'(o_reset), 32'h6);
            if (r == 17) chk("t1_e17", 32'(o_reset), 32'h6);
            if (r == 18) chk("t1_e18", 32'(o_reset), 32'h4);
            if (r == 21) chk("t1_rdy21", 32'(o_ready), 32'h0);
            if (r == 22) begin
                chk("t1_e22", 32'(o_reset), 32'h0);
                chk("t1_rdy22", 32'(o_ready), 32'h1);
                chk("t1_cnt", 32'(o_cnt), 32'h0);
            end
        end

        // Glitch during STABLE
        rst_in = 1'b1; locked_in = 1'b0;
        tick();
        rst_in = 1'b0; locked_in = 1'b1;
        for (int r = 0; r <= 31; r++) begin
            if (r == 6) locked_in = 1'b0;
            if (r == 9) locked_in = 1'b1;
            tick();
            if (r == 22) chk("t2_e22", 32'(o_reset), 32'h7);
            if (r == 23) chk("t2_e23", 32'(o_reset), 32'h6);
            if (r == 31) begin
                chk("t2_e31", 32'(o_reset), 32'h0);
                chk("t2_lost", 32'(o_lost), 32'h1);
                chk("t2_cnt", 32'(o_cnt), 32'h1);
            end
        end

        // Lock loss in RUN
        for (int r = 0; r <= 25; r++) begin
            if (r == 0) locked_in = 1'b0;
            if (r == 3) locked_in = 1'b1;
            tick();
            if (r == 1) chk("t3_e1", 32'(o_reset), 32'h0);
            if (r == 2) begin
                chk("t3_e2", 32'(o_reset), 32'h7);
                chk("t3_rdy", 32'(o_ready), 32'h0);
                chk("t3_cnt", 32'(o_cnt), 32'h2);
            end
            if (r == 24) chk("t3_e24", 32'(o_reset), 32'h4);
            if (r == 25) chk("t3_e25", 32'(o_ready), 32'h1);
        end

        // Forced restart in RUN
        for (int r = 0; r <= 21; r++) begin
            force_in = (r == 0);
            tick();
            if (r == 0) begin
                chk("t4_e0", 32'(o_reset), 32'h7);
                chk("t4_cnt", 32'(o_cnt), 32'h2);
            end
            if (r == 20) chk("t4_e20", 32'(o_reset), 32'h4);
            if (r == 21) chk("t4_e21", 32'(o_ready), 32'h1);
        end
        force_in = 1'b0;

        // Saturation and clear
        for (int i = 0; i < 5; i++) begin
            locked_in = 1'b0;
            repeat (4) tick();
            locked_in = 1'b1;
            repeat (4) tick();
        end
        chk("t5_sat", 32'(o_cnt), 32'h3);
        locked_in = 1'b0;
        repeat (2) tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("t5_coin_lost", 32'(o_lost), 32'h1);
        chk("t5_coin_cnt", 32'(o_cnt), 32'h1);
        repeat (2) tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        chk("t5_clr_lost", 32'(o_lost), 32'h0);
        chk("t5_clr_cnt", 32'(o_cnt), 32'h0);

        // Reset during RELEASE
        locked_in = 1'b1;
        repeat (4) tick();
        locked_in = 1'b0;
        repeat (4) tick();
        locked_in = 1'b1;
        for (int r = 0; r <= 15; r++) tick();
        chk("t6_pre", 32'(o_reset), 32'h6);
        rst_in = 1'b1;
        tick();
        chk("t6_reset", 32'(o_reset), 32'h7);
        chk("t6_ready", 32'(o_ready), 32'h0);
        chk("t6_lost", 32'(o_lost), 32'h0);
        chk("t6_cnt", 32'(o_cnt), 32'h0);
        rst_in = 1'b0;
        for (int r = 0; r <= 22; r++) begin
            tick();
            if (r == 21) chk("t6_e21", 32'(o_reset), 32'h4);
            if (r == 22) chk("t6_e22", 32'(o_ready), 32'h1);
        end

        // Randomized operation
        for (int i = 0; i < 4000; i++) begin
            if (locked_in ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 9) == 0))
                locked_in = ~locked_in;
            force_in = ($urandom_range(0, 79) == 0);
            clear_in = ($urandom_range(0, 59) == 0);
            rst_in   = ($urandom_range(0, 699) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
